// File: rtl/char_bus_tx.sv
// Character bus sender: FIFO-buffered bytes replayed as setup/pulse/hold/gap strobe frames.
// Optional built-in 'A'..'Z' test pattern is enabled by defining CHARTX_PATTERN_EN.
module char_bus_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int SETUP_CYC  = 16,
  parameter int PULSE_CYC  = 500000,
  parameter int HOLD_CYC   = 500000,
  parameter int GAP_CYC    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_pattern_start,
  output logic [7:0]                    o_p,
  output logic                          o_strobe,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Counter reloads are one less than the state length: a state ends on the edge where cnt==0.
  localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
  localparam logic [19:0] PULSE_LD = 20'(PULSE_CYC - 1);
  localparam logic [19:0] HOLD_LD  = 20'(HOLD_CYC - 1);
  localparam logic [19:0] GAP_LD   = 20'(GAP_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [19:0]     cnt_q, cnt_d;
  logic [7:0]      p_q, p_d;
  logic            strobe_q, strobe_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic fifo_empty, push, pop, gap_end;
  logic pat_start, pat_active;

  assign fifo_empty = (count_q == '0);
  assign gap_end    = (state_q == S_GAP) && (cnt_q == '0);
  assign o_ready    = (count_q < CW'(FIFO_DEPTH)) && !pat_active;
  assign push       = i_valid && o_ready;

`ifdef CHARTX_PATTERN_EN
  logic pat_q, pat_d;

  assign pat_start  = i_pattern_start && (state_q == S_IDLE) && fifo_empty;
  assign pat_active = pat_q;

  // Pattern walks o_p itself from 'A' upward; 'Z' marks the last frame.
  always_comb begin
    pat_d = pat_q;
    if (pat_start)                        pat_d = 1'b1;
    else if (pat_q && gap_end && p_q == 8'h5A) pat_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) pat_q <= 1'b0;
    else       pat_q <= pat_d;
  end
`else
  logic unused_pattern_start;

  assign unused_pattern_start = i_pattern_start;
  assign pat_start            = 1'b0;
  assign pat_active           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pat_start) begin
          p_d     = 8'h41;
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          p_d     = mem_q[rd_ptr_q];
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LD;
        end else cnt_d = cnt_q - 20'd1;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else cnt_d = cnt_q - 20'd1;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else cnt_d = cnt_q - 20'd1;
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 20'd1;
        end else if (pat_active && p_q != 8'h5A) begin
          p_d     = p_q + 8'd1;
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          p_d     = mem_q[rd_ptr_q];
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    strobe_d = (state_d == S_PULSE);
    busy_d   = (state_d != S_IDLE);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= 8'h00;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_p          = p_q;
  assign o_strobe     = strobe_q;
  assign o_busy       = busy_q;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_char_bus_tx.sv
// Directed bench for char_bus_tx; transmitted characters are checked against a scoreboard queue.
module tb_char_bus_tx;

  localparam int DEPTH = 4;
  localparam int SETUP = 2;
  localparam int PULSE = 3;
  localparam int HOLD  = 4;
  localparam int GAP   = 1;
  localparam int FRAME = SETUP + PULSE + HOLD + GAP;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_pattern_start = 1'b0;
  logic       o_ready, o_strobe, o_busy;
  logic [7:0] o_p;
  logic [$clog2(DEPTH):0] o_fifo_count;

  char_bus_tx #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE),
    .HOLD_CYC(HOLD), .GAP_CYC(GAP)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_pattern_start(i_pattern_start), .o_p(o_p),
    .o_strobe(o_strobe), .o_busy(o_busy), .o_fifo_count(o_fifo_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, hi = 0, npulse = 0, busy_cyc = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] expq [$];
  int rise_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge and run the bus monitor on that sample.
  task automatic tick();
    logic [31:0] ex;
    @(posedge clk);
    #1;
    cyc++;
    if (o_busy) busy_cyc++;
    if (i_rst) begin
      prev_strobe = 1'b0;
    end else begin
      if (o_strobe && !prev_strobe) begin
        rise_q.push_back(cyc);
        hi = 1;
      end else if (o_strobe) begin
        hi++;
      end
      if (!o_strobe && prev_strobe) begin
        npulse++;
        chk("pulse_width", 32'(hi), 32'(PULSE));
        if (expq.size() > 0) ex = {24'h0, expq.pop_front()};
        else                 ex = 'x;
        chk("char_on_fall", {24'h0, o_p}, ex);
      end
      prev_strobe = o_strobe;
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (o_busy && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < bound), 32'd1);
  endtask

  initial begin
    logic [7:0] b3 [3];
    int np0;
    b3 = '{8'h48, 8'h49, 8'h7F};

    // 1: reset
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_p",      {24'h0, o_p},          32'h00);
    chk("rst_strobe", 32'(o_strobe),         32'd0);
    chk("rst_busy",   32'(o_busy),           32'd0);
    chk("rst_ready",  32'(o_ready),          32'd1);
    chk("rst_count",  32'(o_fifo_count),     32'd0);

    // 2: single character, edge-by-edge timing
    i_valid = 1'b1; i_data = 8'h48; expq.push_back(8'h48);
    tick();
    i_valid = 1'b0;
    chk("t2_count0", 32'(o_fifo_count), 32'd1);
    chk("t2_p0",     {24'h0, o_p},      32'h00);
    for (int e = 1; e <= 11; e++) begin
      tick();
      chk($sformatf("t2_strobe_e%0d", e), 32'(o_strobe), 32'(e >= 1 + SETUP && e <= SETUP + PULSE));
      chk($sformatf("t2_busy_e%0d", e),   32'(o_busy),   32'(e <= FRAME));
      if (e <= 9) chk($sformatf("t2_p_e%0d", e), {24'h0, o_p}, 32'h48);
    end
    chk("t2_sb_empty", 32'(expq.size()), 32'd0);

    // 3: back-to-back including 7F
    rise_q.delete(); busy_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_data = b3[i]; expq.push_back(b3[i]);
      tick();
    end
    i_valid = 1'b0;
    wait_idle("t3_timeout", 200);
    chk("t3_rises", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() == 3) begin
      chk("t3_spacing01", 32'(rise_q[1] - rise_q[0]), 32'(FRAME));
      chk("t3_spacing12", 32'(rise_q[2] - rise_q[1]), 32'(FRAME));
    end
    chk("t3_busy_run", 32'(busy_cyc), 32'(3 * FRAME));
    chk("t3_sb_empty", 32'(expq.size()), 32'd0);

    // 4: overfill; fifth push lands because the first was already popped
    np0 = npulse;
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1; i_data = 8'hA0 + 8'(i);
      if (i < 5) expq.push_back(8'hA0 + 8'(i));
      tick();
      if (i == 4) begin
        chk("t4_ready_full", 32'(o_ready),      32'd0);
        chk("t4_count_full", 32'(o_fifo_count), 32'd4);
      end
    end
    i_valid = 1'b0;
    wait_idle("t4_timeout", 300);
    chk("t4_pulses",   32'(npulse - np0), 32'd5);
    chk("t4_sb_empty", 32'(expq.size()),  32'd0);

    // 5: reset during the second strobe-high cycle
    i_valid = 1'b1; i_data = 8'h55; expq.push_back(8'h55);
    tick();
    i_valid = 1'b0;
    for (int n = 0; n < 50 && !o_strobe; n++) tick();
    chk("t5_strobe_seen", 32'(o_strobe), 32'd1);
    tick();
    i_rst = 1'b1;
    tick();
    chk("t5_strobe", 32'(o_strobe),     32'd0);
    chk("t5_count",  32'(o_fifo_count), 32'd0);
    chk("t5_p",      {24'h0, o_p},      32'h00);
    chk("t5_busy",   32'(o_busy),       32'd0);
    i_rst = 1'b0;
    expq.delete();
    np0 = npulse;
    repeat (30) tick();
    chk("t5_no_pulse", 32'(npulse - np0), 32'd0);

`ifdef CHARTX_PATTERN_EN
    // 6: built-in pattern; pushes mid-pattern must be refused
    begin
      int ready_hi = 0;
      int n = 0;
      np0 = npulse;
      for (int i = 0; i < 26; i++) expq.push_back(8'h41 + 8'(i));
      i_pattern_start = 1'b1;
      tick();
      i_pattern_start = 1'b0;
      while (o_busy && n < 400) begin
        i_valid = (n >= 50 && n < 53);
        i_data  = 8'h99;
        if (o_ready) ready_hi++;
        tick();
        n++;
      end
      i_valid = 1'b0;
      chk("t6_timeout",  32'(n < 400),       32'd1);
      chk("t6_pulses",   32'(npulse - np0),  32'd26);
      chk("t6_ready_lo", 32'(ready_hi),      32'd0);
      chk("t6_sb_empty", 32'(expq.size()),   32'd0);
      repeat (30) tick();
      chk("t6_no_extra", 32'(npulse - np0),  32'd26);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
